// File: rtl/param_register_file_if.sv
// Bundles the register-file read ports, write port and bulk-clear control.
// Decode/write-back logic attaches as master; the register file as slave.
interface param_register_file_if #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [WIDTH-1:0]  rd_data1;
  logic [WIDTH-1:0]  rd_data2;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic              clr_start;
  logic              busy;

  modport master (
    output rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, clr_start,
    input  rd_data1, rd_data2, busy
  );

  modport slave (
    input  rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, clr_start,
    output rd_data1, rd_data2, busy
  );
endinterface

// File: rtl/param_register_file.sv
// Parametrised register file: two combinational read ports, one write port,
// optional hardwired-zero r0, write-to-read bypass and a sequenced bulk clear.
module param_register_file #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  param_register_file_if.slave rf
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] clr_cnt;
  logic [ADDR_W-1:0] clr_cnt_nxt;
  logic [WIDTH-1:0]  regs [DEPTH];
  logic              wr_fire;
  logic [WIDTH-1:0]  rd_data1;
  logic [WIDTH-1:0]  rd_data2;

  // An address is "live" when it names a real register that is not hardwired to zero.
  function automatic logic addr_live(input logic [ADDR_W-1:0] a);
    logic in_range;
    in_range = (32'(a) < DEPTH);
    return in_range && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign wr_fire = (state == IDLE) && rf.wr_en && addr_live(rf.wr_addr);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state   <= IDLE;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    case (state)
      IDLE: begin
        if (rf.clr_start) begin
          state_nxt   = CLEAR;
          clr_cnt_nxt = '0;
        end
      end
      CLEAR: begin
        // Counter stops at DEPTH-1; the sweep ends on the edge that clears it.
        if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
          state_nxt   = IDLE;
          clr_cnt_nxt = '0;
        end else begin
          clr_cnt_nxt = clr_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt   = IDLE;
        clr_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (state == CLEAR) begin
      regs[clr_cnt] <= '0;
    end else if (wr_fire) begin
      regs[rf.wr_addr] <= rf.wr_data;
    end
  end

  // Read ports: dead addresses read zero; a legal same-cycle write is forwarded.
  always_comb begin
    rd_data1 = '0;
    if (addr_live(rf.rd_addr1)) begin
      if ((BYPASS != 0) && wr_fire && (rf.wr_addr == rf.rd_addr1)) begin
        rd_data1 = rf.wr_data;
      end else begin
        rd_data1 = regs[rf.rd_addr1];
      end
    end
  end

  always_comb begin
    rd_data2 = '0;
    if (addr_live(rf.rd_addr2)) begin
      if ((BYPASS != 0) && wr_fire && (rf.wr_addr == rf.rd_addr2)) begin
        rd_data2 = rf.wr_data;
      end else begin
        rd_data2 = regs[rf.rd_addr2];
      end
    end
  end

  assign rf.rd_data1 = rd_data1;
  assign rf.rd_data2 = rd_data2;
  assign rf.busy     = (state == CLEAR);

endmodule
